// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg -- shared AES definitions for the inverse SubBytes block.
//   AES_BLOCK_W / AES_BYTES : state width in bits / bytes
//   state_t                 : FSM states of aes_inv_sub_bytes
//   INV_SBOX                : 256-entry inverse S-box, indexed by input byte
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTES   = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/inv_sbox.sv
// ---------------------------------------------------------------------------
// inv_sbox -- combinational AES inverse S-box for one byte.
//   a : input byte
//   c : InvSBox(a)
// ---------------------------------------------------------------------------
module inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] c
);

    always_comb begin
        c = INV_SBOX[a];
    end

endmodule

// File: rtl/aes_inv_sub_bytes.sv
// ---------------------------------------------------------------------------
// aes_inv_sub_bytes -- iterative AES InvSubBytes over a 128-bit state,
// LANES bytes per cycle (LANES = 1, 2, 4, 8 or 16).
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake, in_data byte i = in_data[8i+7:8i]
//   out_valid/out_ready : output handshake, out_data = InvSubBytes(in_data)
//   busy                : high while a block is being processed or held
// Optional macro AES_INV_SBOX_PIPE_EN registers the S-box outputs and their
// group index before write-back (one extra cycle of latency).
// ---------------------------------------------------------------------------
module aes_inv_sub_bytes
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic                   busy
);

    localparam int GROUPS = AES_BYTES / LANES;
    localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(GROUPS - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [AES_BLOCK_W-1:0] r_work;
    logic [CNT_W-1:0]       r_cnt;
    logic [LANES-1:0][7:0]  w_sb_in;
    logic [LANES-1:0][7:0]  w_sb_out;
    logic                   w_in_hs;
    logic                   w_out_hs;
    logic                   w_run_done;

    // Lane l looks at byte r_cnt*LANES + l of the working register.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_sb_in[l] = r_work[(int'(r_cnt) * LANES + l) * 8 +: 8];
        inv_sbox u_inv_sbox (
            .a (w_sb_in[l]),
            .c (w_sb_out[l])
        );
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
        busy      = (r_state != ST_IDLE);
        out_data  = r_work;
        w_in_hs   = in_valid  && (r_state == ST_IDLE);
        w_out_hs  = out_ready && (r_state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_in_hs)    w_state_nxt = ST_RUN;
            ST_RUN:  if (w_run_done) w_state_nxt = ST_DONE;
            ST_DONE: if (w_out_hs)   w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef AES_INV_SBOX_PIPE_EN
    logic [LANES-1:0][7:0] r_pipe_data;
    logic [CNT_W-1:0]      r_pipe_grp;
    logic                  r_pipe_vld;
    logic                  r_issued;

    // Once every group has been issued, the next RUN edge drains the pipe
    // register into the last group and leaves RUN.
    always_comb begin
        w_run_done = r_issued;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_work      <= '0;
            r_cnt       <= '0;
            r_pipe_data <= '0;
            r_pipe_grp  <= '0;
            r_pipe_vld  <= 1'b0;
            r_issued    <= 1'b0;
        end else if (w_in_hs) begin
            r_work     <= in_data;
            r_cnt      <= '0;
            r_pipe_vld <= 1'b0;
            r_issued   <= 1'b0;
        end else if (r_state == ST_RUN) begin
            if (!r_issued) begin
                r_pipe_data <= w_sb_out;
                r_pipe_grp  <= r_cnt;
                r_pipe_vld  <= 1'b1;
                if (r_cnt == LAST_GRP) begin
                    r_issued <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_pipe_vld <= 1'b0;
            end
            if (r_pipe_vld) begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    r_work[(int'(r_pipe_grp) * LANES + int'(l)) * 8 +: 8] <= r_pipe_data[l];
                end
            end
        end
    end
`else
    always_comb begin
        w_run_done = (r_cnt == LAST_GRP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_work <= '0;
            r_cnt  <= '0;
        end else if (w_in_hs) begin
            r_work <= in_data;
            r_cnt  <= '0;
        end else if (r_state == ST_RUN) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                r_work[(int'(r_cnt) * LANES + int'(l)) * 8 +: 8] <= w_sb_out[l];
            end
            // Counter parks on the last group; the FSM leaves RUN there.
            if (r_cnt != LAST_GRP) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_aes_inv_sub_bytes.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_sub_bytes -- bench for aes_inv_sub_bytes with LANES = 1..16.
// The reference inverse S-box is derived from GF(2^8) arithmetic and the
// forward affine transform, independent of the design's lookup table.
// ---------------------------------------------------------------------------
module tb_aes_inv_sub_bytes;

    localparam int N = 5;
`ifdef AES_INV_SBOX_PIPE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    localparam logic [127:0] ALL63  = {16{8'h63}};
    localparam logic [127:0] ALL16  = {16{8'h16}};
    localparam logic [127:0] ALLFF  = {16{8'hff}};
    localparam logic [127:0] ALL52  = {16{8'h52}};
    localparam logic [127:0] SEQ    = 128'h76abd7fe2b670130c56f6bf27b777c63;
    localparam logic [127:0] SEQINV = 128'h0f0e0d0c0b0a09080706050403020100;

    logic         clk = 1'b0;
    logic         rst;
    logic         iv   [N];
    logic [127:0] id   [N];
    logic         ordy [N];
    logic         ir   [N];
    logic         ov   [N];
    logic         bz   [N];
    logic [127:0] od   [N];

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        aes_inv_sub_bytes #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .in_data   (id[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .out_data  (od[g]),
            .busy      (bz[g])
        );
    end

    // ---------------- reference model ----------------
    logic [7:0] inv_tbl [256];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] v;
        v = '0;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) v = 8'(y);
        end
        return v ^ rl(v) ^ rl(rl(v)) ^ rl(rl(rl(v))) ^ rl(rl(rl(rl(v)))) ^ 8'h63;
    endfunction

    initial begin
        for (int x = 0; x < 256; x++) inv_tbl[fwd_sbox(8'(x))] = 8'(x);
    end

    function automatic logic [127:0] model_blk(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tbl[d[8*i +: 8]];
        return r;
    endfunction

    function automatic int lat(input int k);
        return 16 / (1 << k) + PIPE;
    endfunction

    // Abstract transaction model: 0 idle, 1 processing, 2 result held.
    int           m_mode [N];
    int           m_rem  [N];
    logic [127:0] m_exp  [N];
    logic [127:0] m_last [N];

    initial begin
        for (int k = 0; k < N; k++) begin
            m_mode[k] = 0; m_rem[k] = 0; m_exp[k] = '0; m_last[k] = '0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                m_mode[k] = 0;
                m_last[k] = '0;
            end else if (m_mode[k] == 0) begin
                if (iv[k]) begin
                    m_mode[k] = 1;
                    m_rem[k]  = lat(k);
                    m_exp[k]  = model_blk(id[k]);
                end
            end else if (m_mode[k] == 1) begin
                m_rem[k] = m_rem[k] - 1;
                if (m_rem[k] == 0) begin
                    m_mode[k] = 2;
                    m_last[k] = m_exp[k];
                end
            end else begin
                if (ordy[k]) m_mode[k] = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < N; k++) begin
                chk($sformatf("L%0d in_ready", 1 << k),  128'(ir[k]), 128'(m_mode[k] == 0));
                chk($sformatf("L%0d out_valid", 1 << k), 128'(ov[k]), 128'(m_mode[k] == 2));
                chk($sformatf("L%0d busy", 1 << k),      128'(bz[k]), 128'(m_mode[k] != 0));
                if (m_mode[k] != 1)
                    chk($sformatf("L%0d out_data", 1 << k), od[k], m_last[k]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_valid(input int k, output int cyc);
        cyc = 0;
        while (!ov[k] && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_block(input int k, input logic [127:0] d, input logic [127:0] exp, input string tag);
        int cyc;
        id[k] = d; iv[k] = 1'b1; ordy[k] = 1'b1;
        cyc = 0;
        while (!ir[k] && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        iv[k] = 1'b0;
        wait_valid(k, cyc);
        chk($sformatf("L%0d %s latency", 1 << k, tag), 128'(cyc), 128'(lat(k)));
        chk($sformatf("L%0d %s data", 1 << k, tag), od[k], exp);
        @(posedge clk); #1;
        ordy[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            iv[k] = 1'b0; id[k] = '0; ordy[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        chk("reset in_ready", 128'(ir[2]), 128'(1));
        chk("reset out_valid", 128'(ov[2]), 128'(0));
        chk("reset busy", 128'(bz[2]), 128'(0));
        chk("reset out_data", od[2], 128'h0);

        chk("model 63", model_blk(ALL63), 128'h0);
        chk("model 00", model_blk(128'h0), ALL52);
        chk("model 16", model_blk(ALL16), ALLFF);
        chk("model seq", model_blk(SEQ), SEQINV);

        for (int k = 0; k < N; k++) begin
            run_block(k, ALL63, 128'h0, "all63");
            run_block(k, SEQ, SEQINV, "seq");
        end
        run_block(2, 128'h0, ALL52, "zeros");
        run_block(2, ALL16, ALLFF, "all16");

        // Backpressure: hold result while a new block waits at the input.
        id[2] = SEQ; iv[2] = 1'b1; ordy[2] = 1'b0;
        @(posedge clk); #1;
        iv[2] = 1'b0;
        wait_valid(2, cyc);
        chk("bp latency", 128'(cyc), 128'(lat(2)));
        id[2] = ALL16; iv[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp hold out_valid", 128'(ov[2]), 128'(1));
            chk("bp hold in_ready", 128'(ir[2]), 128'(0));
            chk("bp hold out_data", od[2], SEQINV);
        end
        ordy[2] = 1'b1;
        @(posedge clk); #1;
        ordy[2] = 1'b0;
        chk("bp release in_ready", 128'(ir[2]), 128'(1));
        chk("bp release out_valid", 128'(ov[2]), 128'(0));
        @(posedge clk); #1;
        iv[2] = 1'b0;
        chk("bp accept busy", 128'(bz[2]), 128'(1));
        chk("bp accept in_ready", 128'(ir[2]), 128'(0));
        wait_valid(2, cyc);
        chk("bp second latency", 128'(cyc), 128'(lat(2)));
        chk("bp second data", od[2], ALLFF);
        ordy[2] = 1'b1;
        @(posedge clk); #1;
        ordy[2] = 1'b0;

        // Reset in the second processing cycle aborts the block.
        id[2] = SEQ; iv[2] = 1'b1;
        @(posedge clk); #1;
        iv[2] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort out_valid", 128'(ov[2]), 128'(0));
        chk("abort in_ready", 128'(ir[2]), 128'(1));
        chk("abort busy", 128'(bz[2]), 128'(0));
        chk("abort out_data", od[2], 128'h0);
        run_block(2, ALL63, 128'h0, "after abort");

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
